// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared owner encoding and constants for the data-memory arbiter.
// Imported by dmem_arbiter and dmem_rr_pick.
package dmem_arb_pkg;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DBG = 1'b1
   } owner_e;

   localparam int MAX_HOLD_DEF   = 4;
   localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: combinational two-port grant pick with a bounded hold.
// gnt[0] = CPU, gnt[1] = debug; at most one bit set.
module dmem_rr_pick
   import dmem_arb_pkg::*;
#(
   parameter int MAX_HOLD = MAX_HOLD_DEF,
   parameter int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
   input  logic              cpu_req,
   input  logic              dbg_req,
   input  logic              last_owner,
   input  logic [HOLD_W-1:0] hold_cnt,
   output logic [1:0]        gnt
);

   logic keep;

   // A zero count means no live streak, so contention goes to the other port.
   assign keep = (hold_cnt != '0) && (hold_cnt < HOLD_W'(MAX_HOLD));

   always_comb begin
      gnt = 2'b00;
      unique case ({dbg_req, cpu_req})
         2'b01: gnt = 2'b01;
         2'b10: gnt = 2'b10;
         2'b11: begin
            if (last_owner == OWN_DBG)
               gnt = keep ? 2'b10 : 2'b01;
            else
               gnt = keep ? 2'b01 : 2'b10;
         end
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the big-endian byte-addressed data memory between CPU and debug ports.
// Define DMEM_ARB_ERR_EN to trap misaligned accesses and expose the err port.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32,
   parameter int MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
`ifdef DMEM_ARB_ERR_EN
   output logic              err,
`endif
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int HOLD_W = $clog2(MAX_HOLD + 1);

   owner_e            last_owner;
   owner_e            gnt_owner;
   logic [HOLD_W-1:0] hold_cnt;
   logic [1:0]        pick;
   logic              any_gnt;
   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata;
   logic              mis;
   logic [DATA_W-1:0] rd_word;

   dmem_rr_pick #(
      .MAX_HOLD (MAX_HOLD),
      .HOLD_W   (HOLD_W)
   ) u_pick (
      .cpu_req    (cpu_req),
      .dbg_req    (dbg_req),
      .last_owner (last_owner),
      .hold_cnt   (hold_cnt),
      .gnt        (pick)
   );

   // No access may start while reset is held.
   assign cpu_gnt   = pick[0] & ~rst;
   assign dbg_gnt   = pick[1] & ~rst;
   assign any_gnt   = cpu_gnt | dbg_gnt;
   assign gnt_owner = dbg_gnt ? OWN_DBG : OWN_CPU;

   assign a_we    = dbg_gnt ? dbg_we    : cpu_we;
   assign a_addr  = dbg_gnt ? dbg_addr  : cpu_addr;
   assign a_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;

`ifdef DMEM_ARB_ERR_EN
   localparam int OFF_W = $clog2(BYTES_PER_WORD);
   assign mis = |a_addr[OFF_W-1:0];
`else
   assign mis = 1'b0;
`endif

   assign mem_we    = any_gnt & a_we & ~mis;
   assign mem_addr  = any_gnt ? a_addr  : '0;
   assign mem_wdata = any_gnt ? a_wdata : '0;
   assign rd_word   = mis ? '0 : mem_rdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_owner <= OWN_DBG;
         hold_cnt   <= '0;
         cpu_rvalid <= 1'b0;
         dbg_rvalid <= 1'b0;
         cpu_rdata  <= '0;
         dbg_rdata  <= '0;
      end else begin
         cpu_rvalid <= cpu_gnt & ~cpu_we;
         dbg_rvalid <= dbg_gnt & ~dbg_we;
         if (cpu_gnt & ~cpu_we)
            cpu_rdata <= rd_word;
         if (dbg_gnt & ~dbg_we)
            dbg_rdata <= rd_word;
         if (!any_gnt) begin
            hold_cnt <= '0;
         end else if (gnt_owner == last_owner) begin
            if (hold_cnt != HOLD_W'(MAX_HOLD))
               hold_cnt <= hold_cnt + HOLD_W'(1);
         end else begin
            last_owner <= gnt_owner;
            hold_cnt   <= HOLD_W'(1);
         end
      end
   end

`ifdef DMEM_ARB_ERR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err <= 1'b0;
      else
         err <= any_gnt & mis;
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a behavioural byte memory.
// Honours DMEM_ARB_ERR_EN when defined for the build.
module tb_dmem_arbiter;

   typedef struct {
      logic [31:0] d;
      logic        e;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [4:0]  cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic        cpu_gnt, cpu_rvalid;
   logic [31:0] cpu_rdata;
   logic        dbg_req = 1'b0, dbg_we = 1'b0;
   logic [4:0]  dbg_addr = '0;
   logic [31:0] dbg_wdata = '0;
   logic        dbg_gnt, dbg_rvalid;
   logic [31:0] dbg_rdata;
   logic        mem_we;
   logic [4:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
`ifdef DMEM_ARB_ERR_EN
   logic        err;
`endif

   logic [7:0]  mem [32];
   logic [7:0]  mdl [32];
   logic        mem_init = 1'b1;
   logic [4:0]  a1, a2, a3;
   exp_t        cpu_q[$];
   exp_t        dbg_q[$];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .dbg_req    (dbg_req),
      .dbg_we     (dbg_we),
      .dbg_addr   (dbg_addr),
      .dbg_wdata  (dbg_wdata),
      .dbg_gnt    (dbg_gnt),
      .dbg_rvalid (dbg_rvalid),
      .dbg_rdata  (dbg_rdata),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
`ifdef DMEM_ARB_ERR_EN
      .err        (err),
`endif
      .mem_rdata  (mem_rdata)
   );

   function automatic logic [7:0] pat(input int i);
      return 8'(i * 7 + 48);
   endfunction

   // Behavioural big-endian array with byte wrap.
   assign a1 = mem_addr + 5'd1;
   assign a2 = mem_addr + 5'd2;
   assign a3 = mem_addr + 5'd3;
   assign mem_rdata = {mem[mem_addr], mem[a1], mem[a2], mem[a3]};

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 32; i++) mem[i] <= pat(i);
      end else if (mem_we) begin
         mem[mem_addr] <= mem_wdata[31:24];
         mem[a1]       <= mem_wdata[23:16];
         mem[a2]       <= mem_wdata[15:8];
         mem[a3]       <= mem_wdata[7:0];
      end
   end

   function automatic bit misal(input logic [4:0] a);
`ifdef DMEM_ARB_ERR_EN
      return a[1:0] != 2'b00;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_access(input bit d, input logic we,
                               input logic [4:0] a, input logic [31:0] w);
      logic [4:0] b1, b2, b3;
      exp_t       x;
      b1 = a + 5'd1;
      b2 = a + 5'd2;
      b3 = a + 5'd3;
      if (we) begin
         if (!misal(a)) begin
            mdl[a]  = w[31:24];
            mdl[b1] = w[23:16];
            mdl[b2] = w[15:8];
            mdl[b3] = w[7:0];
         end
      end else begin
         x.e = misal(a);
         x.d = x.e ? 32'h0 : {mdl[a], mdl[b1], mdl[b2], mdl[b3]};
         if (d) dbg_q.push_back(x);
         else   cpu_q.push_back(x);
      end
   endtask

   // Scoreboard: pop on rvalid, push on each observed grant.
   initial begin
      exp_t x;
      for (int i = 0; i < 32; i++) mdl[i] = pat(i);
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            if (cpu_rvalid) begin
               checks++;
               if (cpu_q.size() == 0) begin
                  errors++;
                  $display("FAIL cpu_rvalid_unexpected rdata=%h", cpu_rdata);
               end else begin
                  x = cpu_q.pop_front();
                  if (cpu_rdata !== x.d) begin
                     errors++;
                     $display("FAIL cpu_rdata got=%h exp=%h", cpu_rdata, x.d);
                  end
`ifdef DMEM_ARB_ERR_EN
                  checks++;
                  if (err !== x.e) begin
                     errors++;
                     $display("FAIL cpu_err got=%b exp=%b", err, x.e);
                  end
`endif
               end
            end
            if (dbg_rvalid) begin
               checks++;
               if (dbg_q.size() == 0) begin
                  errors++;
                  $display("FAIL dbg_rvalid_unexpected rdata=%h", dbg_rdata);
               end else begin
                  x = dbg_q.pop_front();
                  if (dbg_rdata !== x.d) begin
                     errors++;
                     $display("FAIL dbg_rdata got=%h exp=%h", dbg_rdata, x.d);
                  end
               end
            end
            if (cpu_req && cpu_gnt)
               model_access(1'b0, cpu_we, cpu_addr, cpu_wdata);
            if (dbg_req && dbg_gnt)
               model_access(1'b1, dbg_we, dbg_addr, dbg_wdata);
         end
      end
   end

   task automatic issue(input bit d, input logic we,
                        input logic [4:0] a, input logic [31:0] w);
      int n;
      bit got;
      n = 0;
      got = 1'b0;
      @(negedge clk);
      if (d) begin
         dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = w;
      end else begin
         cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = w;
      end
      while (!got && n < 20) begin
         #1;
         if (d ? dbg_gnt : cpu_gnt) got = 1'b1;
         else begin
            n++;
            @(negedge clk);
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL grant_timeout port=%0d gnt=0 exp=1", d);
      end
      @(posedge clk);
      #1;
      if (d) dbg_req = 1'b0;
      else   cpu_req = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      cpu_q.delete();
      dbg_q.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      #1;
      checks++;
      if ({cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_we} !== 5'b0 ||
          cpu_rdata !== 32'h0 || dbg_rdata !== 32'h0 ||
          mem_addr !== 5'h0 || mem_wdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_state gnt=%b%b rv=%b%b we=%b addr=%h exp=all0",
                  cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_we, mem_addr);
      end
      rst = 1'b0;
      mem_init = 1'b0;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd8;
      @(posedge clk);
      #2;
      rst = 1'b1;
      cpu_q.delete();
      @(negedge clk);
      #1;
      checks++;
      if (cpu_rvalid !== 1'b0 || cpu_gnt !== 1'b0 || mem_we !== 1'b0 ||
          mem_addr !== 5'h0 || cpu_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_midread rv=%b gnt=%b addr=%h rdata=%h exp=0",
                  cpu_rvalid, cpu_gnt, mem_addr, cpu_rdata);
      end
      cpu_req = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (cpu_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL reset_rvalid_stays got=%b exp=0", cpu_rvalid);
      end
   endtask

   task automatic test_cpu_only();
      issue(1'b0, 1'b1, 5'd8, 32'hDEADBEEF);
      @(negedge clk);
      #1;
      checks++;
      if ({mem[8], mem[9], mem[10], mem[11]} !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL cpu_write_bytes got=%h%h%h%h exp=deadbeef",
                  mem[8], mem[9], mem[10], mem[11]);
      end
      issue(1'b0, 1'b0, 5'd8, 32'h0);
      @(negedge clk);
      #1;
      checks++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL cpu_read rv=%b rdata=%h exp=1/deadbeef",
                  cpu_rvalid, cpu_rdata);
      end
      @(negedge clk);
      #1;
      checks++;
      if (cpu_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL cpu_rvalid_pulse got=%b exp=0", cpu_rvalid);
      end
   endtask

   task automatic test_contention();
      logic [9:0] exp_d;
      exp_d = 10'b00_1111_0000;
      do_reset();
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd0;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd16;
      for (int i = 0; i < 10; i++) begin
         #1;
         checks++;
         if (cpu_gnt !== ~exp_d[i] || dbg_gnt !== exp_d[i]) begin
            errors++;
            $display("FAIL contention_gnt cyc=%0d got=%b%b exp=%b%b",
                     i, cpu_gnt, dbg_gnt, ~exp_d[i], exp_d[i]);
         end
         if (i > 0) begin
            checks++;
            if (cpu_rvalid !== ~exp_d[i-1] || dbg_rvalid !== exp_d[i-1]) begin
               errors++;
               $display("FAIL contention_rvalid cyc=%0d got=%b%b exp=%b%b",
                        i, cpu_rvalid, dbg_rvalid, ~exp_d[i-1], exp_d[i-1]);
            end
         end
         @(negedge clk);
      end
      cpu_req = 1'b0;
      dbg_req = 1'b0;
   endtask

   task automatic test_wrap();
      logic [31:0] exp;
      exp = {16'h3344, pat(0), pat(1)};
      issue(1'b1, 1'b1, 5'd28, 32'h11223344);
      issue(1'b1, 1'b0, 5'd30, 32'h0);
      @(negedge clk);
      #1;
      checks++;
      if (dbg_rvalid !== 1'b1 || dbg_rdata !== exp) begin
         errors++;
         $display("FAIL wrap_read rv=%b rdata=%h exp=%h", dbg_rvalid, dbg_rdata, exp);
      end
   endtask

   task automatic test_coherence();
      logic [31:0] old;
      old = {pat(4), pat(5), pat(6), pat(7)};
      do_reset();
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd4;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd4; dbg_wdata = 32'hA5A5A5A5;
      #1;
      checks++;
      if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin
         errors++;
         $display("FAIL coh_first_gnt got=%b%b exp=10", cpu_gnt, dbg_gnt);
      end
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (dbg_gnt !== 1'b1 || cpu_rvalid !== 1'b1 || cpu_rdata !== old) begin
         errors++;
         $display("FAIL coh_old_read gnt=%b rv=%b rdata=%h exp=1/1/%h",
                  dbg_gnt, cpu_rvalid, cpu_rdata, old);
      end
      @(posedge clk);
      #1;
      dbg_req = 1'b0;
      issue(1'b0, 1'b0, 5'd4, 32'h0);
      @(negedge clk);
      #1;
      checks++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hA5A5A5A5) begin
         errors++;
         $display("FAIL coh_new_read rv=%b rdata=%h exp=1/a5a5a5a5",
                  cpu_rvalid, cpu_rdata);
      end
   endtask

   task automatic test_misaligned();
      logic        exp_we;
      logic [31:0] exp_bytes;
      logic [31:0] exp_rd;
`ifdef DMEM_ARB_ERR_EN
      exp_we    = 1'b0;
      exp_bytes = 32'hA5A5A5DE;
      exp_rd    = 32'h0;
`else
      exp_we    = 1'b1;
      exp_bytes = 32'hCAFEF00D;
      exp_rd    = 32'hCAFEF00D;
`endif
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd5; cpu_wdata = 32'hCAFEF00D;
      #1;
      checks++;
      if (cpu_gnt !== 1'b1 || mem_we !== exp_we) begin
         errors++;
         $display("FAIL mis_we gnt=%b we=%b exp=1/%b", cpu_gnt, mem_we, exp_we);
      end
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
      @(negedge clk);
      #1;
`ifdef DMEM_ARB_ERR_EN
      checks++;
      if (err !== 1'b1 || cpu_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL mis_err err=%b rv=%b exp=1/0", err, cpu_rvalid);
      end
`endif
      checks++;
      if ({mem[5], mem[6], mem[7], mem[8]} !== exp_bytes) begin
         errors++;
         $display("FAIL mis_bytes got=%h%h%h%h exp=%h",
                  mem[5], mem[6], mem[7], mem[8], exp_bytes);
      end
      issue(1'b0, 1'b0, 5'd5, 32'h0);
      @(negedge clk);
      #1;
      checks++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== exp_rd) begin
         errors++;
         $display("FAIL mis_read rv=%b rdata=%h exp=1/%h", cpu_rvalid, cpu_rdata, exp_rd);
      end
   endtask

   initial begin
      test_reset();
      test_cpu_only();
      test_contention();
      test_wrap();
      test_coherence();
      test_misaligned();
      repeat (3) @(negedge clk);
      checks++;
      if (cpu_q.size() != 0 || dbg_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain cpu=%0d dbg=%0d exp=0/0",
                  cpu_q.size(), dbg_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL global_timeout time=%0t", $time);
      $fatal(1, "timeout");
   end

endmodule
